mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath; it replaces single-cycle opcode decoding with a state machine.
- Steps each instruction through fetch, decode, execute, memory and writeback, one state per cycle.
- Stalls on a memory-ready handshake.
- Flags illegal opcodes and counts retired instructions.
- Sits between the instruction register (OpCode source) and the datapath muxes, register file, ALU and memory enables.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
OpCode  input  6  instruction bits [31:26] from IR, stable from DECODE onward
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
PCEn  output  1  PC load enable = PCWrite | (PCWriteCond & Zero)
IorD  output  1  0: memory address from PC, 1: address from ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load enable
MemToReg  output  1  register-file write data from MDR
RegDst  output  1  destination register is rd (1) or rt (0)
RegWrite  output  1  register-file write enable
ALUSrcA  output  1  0: PC, 1: register A
ALUSrcB  output  2  00: B, 01: constant 4, 10: sign-extended immediate, 11: sign-extended immediate << 2
ALUOp  output  3  000 add, 001 sub, 010 R-type funct, 011 and, 100 or, 101 slt
PCSource  output  2  00: ALU result, 01: ALUOut, 10: jump target
illegal  output  1  sticky illegal-opcode flag
state  output  4  current state encoding, for debug
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset is asynchronous, active-high.
  - Reset sets state to IDLE, clears illegal and sets retired to 0.
  - In IDLE all control outputs are 0.
- Outputs:
  - All outputs are combinational from the state (Moore), with one exception.
  - In FETCH, PCWrite and IRWrite are additionally gated by mem_ready.
- Any output not listed for a state is 0.
- States and transitions:
  - IDLE: always -> FETCH.
  - FETCH:
    - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
    - IRWrite=PCWrite=mem_ready.
    - Stay in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (precompute branch target). Next state by OpCode:
    - 000000 -> R_EXEC
    - 100011 (lw) and 101011 (sw) -> MEM_ADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> I_EXEC
    - any other opcode -> ILLEGAL
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. -> MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: MemRead=1, IorD=1. Hold while mem_ready=0; -> MEM_WB when mem_ready=1.
  - MEM_WB: RegDst=0, MemToReg=1, RegWrite=1. -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. Hold while mem_ready=0; -> FETCH when mem_ready=1.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. -> R_WB.
  - R_WB: RegDst=1, RegWrite=1. -> FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp: addi 000, andi 011, ori 100, slti 101. -> I_WB.
  - I_WB: RegDst=0, RegWrite=1. -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. -> FETCH.
  - JUMP: PCWrite=1, PCSource=10. -> FETCH.
  - ILLEGAL: illegal set to 1. Remains in ILLEGAL until reset; all control outputs are 0.
- Per-class cycle counts from FETCH entry to the next FETCH, with zero wait states:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq and j: 3
- retired increments by 1 on the clock edge that leaves MEM_WB, R_WB, I_WB, BRANCH or JUMP. It also increments on the edge leaving MEM_WRITE with mem_ready=1. It wraps modulo 2^CNT_W.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction aborts immediately; no partial write occurs after reset assertion.
- Invariant: MemRead and MemWrite are never 1 in the same cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants
  - ALUOp codes
  - ALUSrcB and PCSource encodings
  - the 4-bit state enum
- Sub-module mc_next_state: purely combinational, taking (state, OpCode, mem_ready) to produce next_state.
- The top level owns the state register, output decode, illegal flag and retired counter.

Test Plan:
- Reset, then R-type (OpCode=000000), mem_ready=1 throughout:
  - Required state sequence: IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH.
  - In R_EXEC: ALUOp=010. In R_WB: RegWrite=1, RegDst=1.
  - retired=1.
- lw with mem_ready low for 3 cycles in MEM_READ:
  - MEM_READ held for 4 cycles with MemRead=1, IorD=1.
  - Then MEM_WB: MemToReg=1, RegWrite=1; retired increments once.
- beq with Zero=1 versus Zero=0:
  - In BRANCH: PCEn=1 and PCSource=01 when Zero=1; PCEn=0 when Zero=0.
  - Both cases -> FETCH, with retired +1.
- FETCH with mem_ready=0 for 2 cycles:
  - IRWrite=0 and PCEn=0 while waiting.
  - IRWrite=1 and PCEn=1 on the mem_ready=1 cycle.
- OpCode=111111 at DECODE:
  - -> ILLEGAL with illegal=1; all enables 0 for 10 cycles.
  - rst pulse clears illegal and returns state to IDLE.
- addi, andi, ori and slti back to back:
  - I_EXEC ALUOp = 000, 011, 100, 101 respectively.
  - retired=4 after 16 cycles from the first FETCH.
  - rst asserted during the second I_WB gives RegWrite=0 immediately.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    ILLEGAL   = 4'd13
  } state_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the sequencer and the MIPS datapath.
interface mc_control_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       OpCode;
  logic             Zero;
  logic             mem_ready;
  logic             PCEn;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemToReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  OpCode, Zero, mem_ready,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, state, retired
  );

  modport slave (
    output OpCode, Zero, mem_ready,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal, state, retired
  );
endinterface

// File: rtl/mc_next_state.sv
// Next-state logic of the multi-cycle sequencer; purely combinational.
module mc_next_state
  import mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output state_t     o_next_state
);

  always_comb begin
    o_next_state = i_state;
    case (i_state)
      IDLE:      o_next_state = FETCH;
      FETCH:     if (i_mem_ready) o_next_state = DECODE;
      DECODE: begin
        case (i_opcode)
          OP_RTYPE:                           o_next_state = R_EXEC;
          OP_LW, OP_SW:                       o_next_state = MEM_ADDR;
          OP_BEQ:                             o_next_state = BRANCH;
          OP_J:                               o_next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  o_next_state = I_EXEC;
          default:                            o_next_state = ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEM_ADDR, so the sw test alone selects the path.
      MEM_ADDR:  o_next_state = (i_opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (i_mem_ready) o_next_state = MEM_WB;
      MEM_WB:    o_next_state = FETCH;
      MEM_WRITE: if (i_mem_ready) o_next_state = FETCH;
      R_EXEC:    o_next_state = R_WB;
      R_WB:      o_next_state = FETCH;
      I_EXEC:    o_next_state = I_WB;
      I_WB:      o_next_state = FETCH;
      BRANCH:    o_next_state = FETCH;
      JUMP:      o_next_state = FETCH;
      ILLEGAL:   o_next_state = ILLEGAL;
      default:   o_next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: state register, Moore output decode,
// sticky illegal-opcode flag and retired-instruction counter.
//   IDLE reset | FETCH read instr | DECODE branch target | MEM_ADDR ld/st addr
//   MEM_READ/MEM_WRITE memory access | MEM_WB load writeback | R_EXEC/R_WB R-type
//   I_EXEC/I_WB immediate ops | BRANCH beq | JUMP j | ILLEGAL trapped until reset
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic [1:0] w_pc_source;

  mc_next_state u_next_state (
    .i_state      (r_state),
    .i_opcode     (bus.OpCode),
    .i_mem_ready  (bus.mem_ready),
    .o_next_state (w_next_state)
  );

  assign w_retire = (r_state inside {MEM_WB, R_WB, I_WB, BRANCH, JUMP}) ||
                    ((r_state == MEM_WRITE) && bus.mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ILLEGAL) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_B;
    w_alu_op        = ALU_ADD;
    w_pc_source     = PCSRC_ALU;
    case (r_state)
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      DECODE:    w_alu_src_b = SRCB_IMM_SH;
      MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      MEM_WB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = imm_alu_op(bus.OpCode);
      end
      I_WB:      w_reg_write = 1'b1;
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.PCEn     = w_pc_write | (w_pc_write_cond & bus.Zero);
  assign bus.IorD     = w_iord;
  assign bus.MemRead  = w_mem_read;
  assign bus.MemWrite = w_mem_write;
  assign bus.IRWrite  = w_ir_write;
  assign bus.MemToReg = w_mem_to_reg;
  assign bus.RegDst   = w_reg_dst;
  assign bus.RegWrite = w_reg_write;
  assign bus.ALUSrcA  = w_alu_src_a;
  assign bus.ALUSrcB  = w_alu_src_b;
  assign bus.ALUOp    = w_alu_op;
  assign bus.PCSource = w_pc_source;
  assign bus.illegal  = r_illegal;
  assign bus.state    = r_state;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class and checks
// state, control vector, illegal flag and retired count against hand values.
module tb_mc_control_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mc_control_fsm_if #(.CNT_W(32)) bus ();

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  // {PCEn,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  logic [15:0] ctl_v;
  assign ctl_v = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                  bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] exp);
    n_vec++;
    assert (bus.state === exp) else begin
      n_err++;
      $error("FAIL %s: state observed %0d expected %0d", tag, bus.state, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [15:0] exp);
    n_vec++;
    assert (ctl_v === exp) else begin
      n_err++;
      $error("FAIL %s: ctl observed %b expected %b", tag, ctl_v, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [5:0] i_ops  [4];
  logic [2:0] i_aluo [4];

  initial begin
    i_ops[0] = 6'b001000; i_aluo[0] = 3'b000;
    i_ops[1] = 6'b001100; i_aluo[1] = 3'b011;
    i_ops[2] = 6'b001101; i_aluo[2] = 3'b100;
    i_ops[3] = 6'b001010; i_aluo[3] = 3'b101;

    rst = 1'b1;
    bus.OpCode = 6'b000000;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    chk_st("rst_state", IDLE);
    chk_ctl("rst_ctl", 16'b0);
    chk_val("rst_illegal", 32'(bus.illegal), 32'd0);
    chk_val("rst_retired", bus.retired, 32'd0);
    rst = 1'b0;

    // R-type
    step(); chk_st("r_fetch", FETCH);
    chk_ctl("r_fetch_ctl", 16'b1_0_1_0_1_0_0_0_0_01_000_00);
    step(); chk_st("r_decode", DECODE);
    chk_ctl("r_decode_ctl", 16'b0_0_0_0_0_0_0_0_0_11_000_00);
    step(); chk_st("r_exec", R_EXEC);
    chk_ctl("r_exec_ctl", 16'b0_0_0_0_0_0_0_0_1_00_010_00);
    step(); chk_st("r_wb", R_WB);
    chk_ctl("r_wb_ctl", 16'b0_0_0_0_0_0_1_1_0_00_000_00);
    chk_val("r_wb_retired", bus.retired, 32'd0);
    step(); chk_st("r_refetch", FETCH);
    chk_val("r_retired", bus.retired, 32'd1);

    // lw with three wait states
    bus.OpCode = 6'b100011;
    step(); chk_st("lw_decode", DECODE);
    step(); chk_st("lw_addr", MEM_ADDR);
    chk_ctl("lw_addr_ctl", 16'b0_0_0_0_0_0_0_0_1_10_000_00);
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      chk_st("lw_memread", MEM_READ);
      chk_ctl("lw_memread_ctl", 16'b0_1_1_0_0_0_0_0_0_00_000_00);
      step();
    end
    chk_st("lw_wb", MEM_WB);
    chk_ctl("lw_wb_ctl", 16'b0_0_0_0_0_1_0_1_0_00_000_00);
    chk_val("lw_wb_retired", bus.retired, 32'd1);
    step(); chk_st("lw_refetch", FETCH);
    chk_val("lw_retired", bus.retired, 32'd2);

    // beq taken, then not taken
    bus.OpCode = 6'b000100;
    bus.Zero = 1'b1;
    step(); step(); chk_st("beq1_branch", BRANCH);
    chk_ctl("beq1_ctl", 16'b1_0_0_0_0_0_0_0_1_00_001_01);
    step(); chk_st("beq1_refetch", FETCH);
    chk_val("beq1_retired", bus.retired, 32'd3);
    bus.Zero = 1'b0;
    step(); step(); chk_st("beq0_branch", BRANCH);
    chk_ctl("beq0_ctl", 16'b0_0_0_0_0_0_0_0_1_00_001_01);
    step(); chk_st("beq0_refetch", FETCH);
    chk_val("beq0_retired", bus.retired, 32'd4);

    // FETCH stall for two cycles, then j
    bus.mem_ready = 1'b0;
    bus.OpCode = 6'b000010;
    #1;
    chk_ctl("fstall0_ctl", 16'b0_0_1_0_0_0_0_0_0_01_000_00);
    step(); chk_st("fstall1", FETCH);
    chk_ctl("fstall1_ctl", 16'b0_0_1_0_0_0_0_0_0_01_000_00);
    bus.mem_ready = 1'b1;
    #1;
    chk_ctl("fready_ctl", 16'b1_0_1_0_1_0_0_0_0_01_000_00);
    step(); chk_st("j_decode", DECODE);
    step(); chk_st("j_jump", JUMP);
    chk_ctl("j_ctl", 16'b1_0_0_0_0_0_0_0_0_00_000_10);
    step(); chk_st("j_refetch", FETCH);
    chk_val("j_retired", bus.retired, 32'd5);

    // sw with one wait state
    bus.OpCode = 6'b101011;
    step(); step(); chk_st("sw_addr", MEM_ADDR);
    step(); chk_st("sw_memwrite", MEM_WRITE);
    chk_ctl("sw_ctl", 16'b0_1_0_1_0_0_0_0_0_00_000_00);
    bus.mem_ready = 1'b0;
    step(); chk_st("sw_hold", MEM_WRITE);
    chk_val("sw_hold_retired", bus.retired, 32'd5);
    bus.mem_ready = 1'b1;
    step(); chk_st("sw_refetch", FETCH);
    chk_val("sw_retired", bus.retired, 32'd6);

    // illegal opcode trap
    bus.OpCode = 6'b111111;
    step(); step(); chk_st("ill_state", ILLEGAL);
    chk_val("ill_flag", 32'(bus.illegal), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      step();
      chk_st("ill_hold", ILLEGAL);
      chk_ctl("ill_ctl", 16'b0);
    end
    chk_val("ill_retired", bus.retired, 32'd6);
    rst = 1'b1;
    #1;
    chk_st("ill_rst_state", IDLE);
    chk_val("ill_rst_flag", 32'(bus.illegal), 32'd0);
    chk_val("ill_rst_retired", bus.retired, 32'd0);
    #1 rst = 1'b0;
    bus.mem_ready = 1'b1;

    // four immediate ops back to back: 16 cycles from first FETCH
    step(); chk_st("imm_fetch", FETCH);
    for (int k = 0; k < 4; k++) begin
      bus.OpCode = i_ops[k];
      step();
      step(); chk_st("imm_exec", I_EXEC);
      chk_ctl("imm_exec_ctl", {9'b0_0_0_0_0_0_0_0_1, 2'b10, i_aluo[k], 2'b00});
      step(); chk_st("imm_wb", I_WB);
      chk_ctl("imm_wb_ctl", 16'b0_0_0_0_0_0_0_1_0_00_000_00);
      step();
    end
    chk_st("imm_refetch", FETCH);
    chk_val("imm_retired", bus.retired, 32'd4);

    // reset during the second I_WB
    rst = 1'b1;
    #2 rst = 1'b0;
    step(); chk_st("abort_fetch", FETCH);
    bus.OpCode = 6'b001000;
    step(); step(); step(); step();
    bus.OpCode = 6'b001100;
    step(); step(); step(); chk_st("abort_iwb", I_WB);
    chk_val("abort_regwrite_pre", 32'(bus.RegWrite), 32'd1);
    chk_val("abort_retired_pre", bus.retired, 32'd1);
    rst = 1'b1;
    #1;
    chk_val("abort_regwrite", 32'(bus.RegWrite), 32'd0);
    chk_st("abort_state", IDLE);
    chk_val("abort_retired", bus.retired, 32'd0);
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
